// File: rtl/proc_prog_feeder.sv
// proc_prog_feeder: loadable program memory and issue FSM that feeds DIN/Run to the 9-bit core.
// Optional Done watchdog is built only when FEEDER_DONE_TIMEOUT_EN is defined.
module proc_prog_feeder #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int TMO_CYCLES = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [8:0]        LdData,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic [ADDR_W:0]   PC,
  output logic [7:0]        InstrCount,
  output logic              Err
);

  localparam logic [2:0]      OP_MVI  = 3'b001;
  localparam logic [2:0]      OP_HALT = 3'b111;
  localparam logic [ADDR_W:0] PC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PC_TWO  = (ADDR_W+1)'(2);

  if (DEPTH != (1 << ADDR_W) || TMO_CYCLES < 1) begin : g_bad_params
    $error("proc_prog_feeder: DEPTH must equal 2**ADDR_W and TMO_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_IMM   = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      din_q, din_d;
  logic            run_q, run_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [ADDR_W:0] pc_inc_s;
  logic [8:0]      cur_word_s;
  logic [8:0]      nxt_word_s;
  logic [8:0]      mem [DEPTH];

`ifdef FEEDER_DONE_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TMO_CYCLES) > 4) ? $clog2(TMO_CYCLES) : 4;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // PC[ADDR_W] set means past the end; low bits then alias only when not read.
  assign pc_inc_s   = pc_q + PC_ONE;
  assign cur_word_s = mem[pc_q[ADDR_W-1:0]];
  assign nxt_word_s = mem[pc_inc_s[ADDR_W-1:0]];

  // Program memory write port, open only while no program is executing.
  always_ff @(posedge Clock) begin
    if (LdEn && (state_q == S_IDLE || state_q == S_HALT)) begin
      mem[LdAddr] <= LdData;
    end
  end

  // Next-state and next-output logic for the issue sequencer.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    run_d    = 1'b0;
    busy_d   = busy_q;
    halted_d = halted_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
`ifdef FEEDER_DONE_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          pc_d     = '0;
          cnt_d    = 8'd0;
          halted_d = 1'b0;
          busy_d   = 1'b1;
`ifdef FEEDER_DONE_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = S_FETCH;
        end else begin
          state_d  = state_q;
        end
      end
      S_FETCH: begin
        if (pc_q[ADDR_W] || cur_word_s[8:6] == OP_HALT) begin
          busy_d   = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          din_d    = cur_word_s;
          run_d    = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FEEDER_DONE_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (din_q[8:6] == OP_MVI) begin
          // An mvi in the last word has no immediate behind it; present zero.
          if (pc_inc_s[ADDR_W]) begin
            din_d = 9'd0;
          end else begin
            din_d = nxt_word_s;
          end
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          pc_d    = pc_q + ((state_q == S_IMM) ? PC_TWO : PC_ONE);
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = S_FETCH;
        end else begin
`ifdef FEEDER_DONE_TIMEOUT_EN
          if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
            err_d    = 1'b1;
            busy_d   = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            tmo_d    = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = state_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous abort on Resetn.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      din_q    <= 9'd0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      cnt_q    <= 8'd0;
`ifdef FEEDER_DONE_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
`ifdef FEEDER_DONE_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign DIN        = din_q;
  assign Run        = run_q;
  assign Busy       = busy_q;
  assign Halted     = halted_q;
  assign PC         = pc_q;
  assign InstrCount = cnt_q;
`ifdef FEEDER_DONE_TIMEOUT_EN
  assign Err        = err_q;
`else
  assign Err        = 1'b0;
`endif

endmodule

// File: tb/tb_proc_prog_feeder.sv
// Self-checking bench for proc_prog_feeder: table of short programs plus end-of-memory,
// mid-wait reset and Done watchdog sequences, with a bench-side model of the core's Done.
module tb_proc_prog_feeder;

  logic       Clock = 1'b0;
  logic       Resetn, Start, LdEn, Done;
  logic [4:0] LdAddr;
  logic [8:0] LdData;
  logic [8:0] DIN;
  logic       Run, Busy, Halted, Err;
  logic [5:0] PC;
  logic [7:0] InstrCount;

  int total = 0;
  int bad   = 0;

  proc_prog_feeder #(.ADDR_W(5), .DEPTH(32), .TMO_CYCLES(15)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .LdEn(LdEn), .LdAddr(LdAddr),
    .LdData(LdData), .Done(Done), .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted),
    .PC(PC), .InstrCount(InstrCount), .Err(Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [8:0] w0, w1, w2, w3;
    int         delay;
    int         exp_runs;
    logic [5:0] exp_pc;
    logic [7:0] exp_cnt;
    logic [8:0] exp_din0;   // DIN while the first Run is high
    logic [8:0] exp_din1;   // DIN in the cycle after the first Run
    logic [8:0] exp_dinl;   // DIN while the last Run is high
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [8:0] data);
    LdEn   = 1'b1;
    LdAddr = addr[4:0];
    LdData = data;
    @(negedge Clock);
    LdEn   = 1'b0;
  endtask

  task automatic start_prog();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Runs the program, answering each Run with Done 'delay' cycles later (at most max_done times).
  task automatic exec(input int delay, input int max_done, input int budget, input int inject_at,
                      input bit hang_ok, output int runs, output int unstable, output int dbl,
                      output int rth, output logic [8:0] din0, output logic [8:0] din1,
                      output logic [8:0] dinl, output logic [8:0] din1l);
    bit       pending = 1'b0;
    bit       first   = 1'b0;
    bit       prev_run = 1'b0;
    bit       halted  = 1'b0;
    int       cd = 0;
    int       ndone = 0;
    int       last_run = 0;
    logic [8:0] hold = 9'd0;
    runs = 0; unstable = 0; dbl = 0; rth = -1;
    din0 = 9'd0; din1 = 9'd0; dinl = 9'd0; din1l = 9'd0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge Clock);
      Done   = 1'b0;
      Start  = (cyc == inject_at);
      LdEn   = (cyc == inject_at);
      LdAddr = 5'd5;
      LdData = 9'o700;
      if (Halted) begin
        halted = 1'b1;
        rth    = cyc - last_run;
        break;
      end
      if (pending) begin
        if (first) begin
          hold  = DIN;
          din1l = DIN;
          if (runs == 1) din1 = DIN;
          first = 1'b0;
        end else if (DIN !== hold) begin
          unstable++;
        end
        cd--;
        if (cd <= 0 && ndone < max_done) begin
          Done    = 1'b1;
          pending = 1'b0;
          ndone++;
        end
      end
      if (Run) begin
        runs++;
        if (prev_run) dbl++;
        if (runs == 1) din0 = DIN;
        dinl     = DIN;
        pending  = 1'b1;
        first    = 1'b1;
        cd       = delay;
        last_run = cyc;
      end
      prev_run = Run;
    end
    Start = 1'b0;
    LdEn  = 1'b0;
    Done  = 1'b0;
    if (!hang_ok) chk("exec_reached_halt", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int runs, unstable, dbl, rth;
    logic [8:0] din0, din1, dinl, din1l;

    Resetn = 1'b1; Start = 1'b0; LdEn = 1'b0; Done = 1'b0; LdAddr = 5'd0; LdData = 9'd0;
    #3 Resetn = 1'b0;
    #10;
    chk("rst_din", DIN, 9'd0);
    chk("rst_run", Run, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_pc", PC, 6'd0);
    chk("rst_cnt", InstrCount, 8'd0);
    chk("rst_err", Err, 1'b0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    vecs[0] = '{9'o010, 9'o700, 9'o700, 9'o700, 1, 1, 6'd1, 8'd1, 9'o010, 9'o010, 9'o010};
    vecs[1] = '{9'o110, 9'h05A, 9'o700, 9'o700, 1, 1, 6'd2, 8'd1, 9'o110, 9'h05A, 9'o110};
    vecs[2] = '{9'o201, 9'o312, 9'o700, 9'o700, 3, 2, 6'd2, 8'd2, 9'o201, 9'o201, 9'o312};
    vecs[3] = '{9'o700, 9'o010, 9'o010, 9'o700, 1, 0, 6'd0, 8'd0, 9'd0,   9'd0,   9'd0};
    vecs[4] = '{9'o512, 9'o700, 9'o700, 9'o700, 2, 1, 6'd1, 8'd1, 9'o512, 9'o512, 9'o512};
    vecs[5] = '{9'o110, 9'o077, 9'o010, 9'o700, 2, 2, 6'd3, 8'd2, 9'o110, 9'o077, 9'o010};

    for (int i = 0; i < 6; i++) begin
      load_word(0, vecs[i].w0);
      load_word(1, vecs[i].w1);
      load_word(2, vecs[i].w2);
      load_word(3, vecs[i].w3);
      start_prog();
      exec(vecs[i].delay, 100, 60, -1, 1'b0, runs, unstable, dbl, rth, din0, din1, dinl, din1l);
      chk($sformatf("v%0d_runs", i), runs, vecs[i].exp_runs);
      chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), InstrCount, vecs[i].exp_cnt);
      chk($sformatf("v%0d_busy", i), Busy, 1'b0);
      chk($sformatf("v%0d_err", i), Err, 1'b0);
      chk($sformatf("v%0d_din_stable", i), unstable, 0);
      chk($sformatf("v%0d_run_width", i), dbl, 0);
      if (vecs[i].exp_runs > 0) begin
        chk($sformatf("v%0d_din0", i), din0, vecs[i].exp_din0);
        chk($sformatf("v%0d_din1", i), din1, vecs[i].exp_din1);
        chk($sformatf("v%0d_dinl", i), dinl, vecs[i].exp_dinl);
      end
    end

    // End of memory: every word is mv; Start and a load of HALT at address 5 mid-run are ignored.
    for (int a = 0; a < 32; a++) load_word(a, 9'o010);
    start_prog();
    exec(1, 100, 200, 10, 1'b0, runs, unstable, dbl, rth, din0, din1, dinl, din1l);
    chk("eom_runs", runs, 32);
    chk("eom_pc", PC, 6'd32);
    chk("eom_cnt", InstrCount, 8'd32);
    chk("eom_halted", Halted, 1'b1);
    chk("eom_run_width", dbl, 0);

    // mvi in the last word: immediate reads as 0 and PC steps past the end to 33.
    load_word(31, 9'o110);
    start_prog();
    exec(1, 100, 200, -1, 1'b0, runs, unstable, dbl, rth, din0, din1, dinl, din1l);
    chk("mvi_end_runs", runs, 32);
    chk("mvi_end_dinl", dinl, 9'o110);
    chk("mvi_end_imm", din1l, 9'd0);
    chk("mvi_end_pc", PC, 6'd33);
    chk("mvi_end_cnt", InstrCount, 8'd32);

    // Reset while waiting on the second instruction's Done.
    load_word(0, 9'o010);
    load_word(1, 9'o010);
    load_word(2, 9'o700);
    start_prog();
    exec(1, 1, 8, -1, 1'b1, runs, unstable, dbl, rth, din0, din1, dinl, din1l);
    chk("midwait_pc", PC, 6'd1);
    chk("midwait_busy", Busy, 1'b1);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_run", Run, 1'b0);
    chk("abort_din", DIN, 9'd0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_pc", PC, 6'd0);
    chk("abort_cnt", InstrCount, 8'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Core never answers.
    load_word(0, 9'o010);
    load_word(1, 9'o700);
    start_prog();
    exec(1, 0, 40, -1, 1'b1, runs, unstable, dbl, rth, din0, din1, dinl, din1l);
    chk("wd_runs", runs, 1);
    chk("wd_pc", PC, 6'd0);
    chk("wd_cnt", InstrCount, 8'd0);
`ifdef FEEDER_DONE_TIMEOUT_EN
    chk("wd_err", Err, 1'b1);
    chk("wd_halted", Halted, 1'b1);
    chk("wd_busy", Busy, 1'b0);
    chk("wd_run_to_halt", rth, 16);
`else
    chk("wd_err", Err, 1'b0);
    chk("wd_halted", Halted, 1'b0);
    chk("wd_busy", Busy, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_prog_feeder.md
Name: proc_prog_feeder

Overview:
Instruction-issuing front end for the 9-bit mv/mvi/add/sub processor core.
- Holds a small loadable program memory.
- Drives the core's DIN and Run inputs and waits on its Done output.
- For mvi, presents the immediate word after the instruction word, then advances the program counter.
- Sits between the board-level test/load logic and the processor core.

Parameters:
- ADDR_W, 5, program memory address width.
- DEPTH, 32, number of 9-bit program words (must equal 2**ADDR_W).
- TMO_CYCLES, 15, Done watchdog limit in cycles (used only with the optional feature).

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse; begins execution at address 0.
- LdEn  input  1  program-memory write enable.
- LdAddr  input  ADDR_W  program-memory write address.
- LdData  input  9  program-memory write data.
- Done  input  1  instruction-complete strobe from the core.
- DIN  output  9  instruction/immediate word to the core.
- Run  output  1  issue strobe to the core.
- Busy  output  1  high while a program is executing.
- Halted  output  1  high after a halt opcode or end of memory.
- PC  output  ADDR_W+1  current program counter. Bit ADDR_W is the end-of-memory flag.
- InstrCount  output  8  instructions completed; saturates at 255.
- Err  output  1  watchdog error flag (tied 0 without the optional feature).

Behaviour:
- Word format: [8:6] opcode, [5:3] X, [2:0] Y. Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT. HALT is consumed by the feeder and never sent to the core. Opcodes 100–110 are issued as-is; the feeder waits for Done.
- Memory: register array, combinational read.
  - Write occurs on a rising edge with LdEn=1, only in IDLE or HALT. LdEn is ignored in all other states.
  - Memory contents are not reset.
- All outputs are registered. Reset values: DIN=0, Run=0, Busy=0, Halted=0, PC=0, InstrCount=0, Err=0, state=IDLE.
- States: IDLE, FETCH, ISSUE, IMM, WAIT, HALT.
- IDLE:
  - Start=1 → PC=0, InstrCount=0, Halted=0, Err=0, Busy=1 → FETCH.
- FETCH:
  - If PC ≥ DEPTH, or mem[PC][8:6]=111 → HALT.
  - Otherwise DIN←mem[PC], Run←1 → ISSUE.
- ISSUE (Run=1 for exactly this one cycle; DIN holds the instruction):
  - Run←0.
  - If opcode=001 and PC+1<DEPTH: DIN←mem[PC+1] → IMM.
  - If opcode=001 and PC+1=DEPTH: DIN←0 → IMM (immediate reads as 0).
  - Otherwise DIN holds → WAIT.
  - Done is ignored in this state.
- IMM / WAIT (DIN held stable):
  - On Done=1: PC←PC+2 (mvi) or PC+1 (others); InstrCount←sat(InstrCount+1) → FETCH.
- HALT:
  - Busy=0, Halted=1, Run=0.
  - Start=1 → restart as in IDLE.
- Latency: one FETCH cycle plus one ISSUE cycle per instruction, plus the core's Done latency. A single-cycle mv (Done one cycle after Run) completes in 3 cycles.
- Start while Busy=1 is ignored. Done while not in IMM/WAIT is ignored.
- PC does not wrap. Reaching DEPTH sets PC[ADDR_W]=1 and the block halts.
- Resetn low at any time aborts immediately: all outputs go to reset values asynchronously, and Run drops in the same instant.

Optional Feature:
- Macro: FEEDER_DONE_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider cycle counter runs in IMM/WAIT and clears on entry to those states.
  - If it reaches TMO_CYCLES without Done: Err←1 → HALT. PC and InstrCount are held.
- Not defined:
  - No counter is built; Err is constant 0.
  - IMM/WAIT wait for Done indefinitely.

Test Plan:
- Reset and memory load:
  - Assert Resetn=0 mid-WAIT → next sample shows Run=0, DIN=0, Busy=0, PC=0.
  - Load with LdEn in IDLE, then read back via execution.
- mv program:
  - Program mem[0]=9'o010 (mv R1,R0), mem[1]=9'o700 (HALT).
  - Start; model returns Done one cycle after Run.
  - Expect Run high 1 cycle with DIN=9'o010, then Halted=1, PC=1, InstrCount=1.
- mvi immediate:
  - Program mem[0]=9'o110, mem[1]=9'h05A, mem[2]=HALT.
  - Expect DIN=9'o110 with Run=1, next cycle DIN=9'h05A held until Done, then PC=2, InstrCount=1, Halted.
- add/sub with slow Done:
  - Program add then sub; Done delayed 3 cycles each.
  - Expect DIN stable throughout WAIT, one Run pulse per instruction, InstrCount=2.
- End of memory:
  - Fill all 32 words with mv.
  - Expect 32 Run pulses, then Halted=1, PC=32.
  - Start and LdEn during execution have no effect.
- Watchdog (with FEEDER_DONE_TIMEOUT_EN):
  - Never return Done.
  - Expect Err=1 and HALT after 15 cycles in WAIT, with PC=0.
  - Without the macro: Busy stays 1 and Err=0.
